// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data memory port between the pipeline and a loader,
// with bounded loader bursts, a starvation guard and 1-cycle read data routing.
module dmem_port_arbiter #(
  parameter int ADDR_WID   = 16,
  parameter int DATA_WID   = 8,
  parameter int MAX_BURST  = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pl_req,
  input  logic                pl_we,
  input  logic [ADDR_WID-1:0] pl_addr,
  input  logic [DATA_WID-1:0] pl_wdata,
  output logic                pl_stall,
  output logic                pl_rvalid,
  output logic [DATA_WID-1:0] pl_rdata,
  input  logic                ld_req,
  input  logic                ld_we,
  input  logic [ADDR_WID-1:0] ld_addr,
  input  logic [DATA_WID-1:0] ld_wdata,
  output logic                ld_gnt,
  output logic                ld_rvalid,
  output logic [DATA_WID-1:0] ld_rdata,
  output logic [ADDR_WID-1:0] dmem_rd_addr,
  output logic [ADDR_WID-1:0] dmem_wr_addr,
  output logic [DATA_WID-1:0] dmem_wr_data,
  output logic                dmem_wr_en,
  input  logic [DATA_WID-1:0] dmem_dout
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  typedef enum logic [1:0] {S_IDLE, S_PL, S_LD} state_t;
  typedef enum logic [1:0] {O_NONE, O_PL, O_LD} owner_t;
  state_t        state, state_nx;
  owner_t        rd_owner, rd_owner_nx;
  logic [BW-1:0] burst_cnt, burst_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic          ld_cont, starved, g_pl, g_ld;
  // Grants are forced low while reset is asserted so every output reads 0 immediately.
  always_comb begin
    ld_cont = state == S_LD && ld_req && (burst_cnt < BW'(MAX_BURST) || !pl_req);
    starved = ld_req && starve_cnt >= SW'(STARVE_LIM);
    g_pl    = rst_n && !ld_cont && pl_req && !starved;
    g_ld    = rst_n && !g_pl && ld_req;
  end
  always_comb begin
    ld_gnt       = g_ld;
    pl_stall     = rst_n && pl_req && !g_pl;
    dmem_rd_addr = g_ld ? ld_addr : g_pl ? pl_addr : '0;
    dmem_wr_addr = dmem_rd_addr;
    dmem_wr_data = g_ld ? ld_wdata : g_pl ? pl_wdata : '0;
    dmem_wr_en   = g_ld ? ld_we : g_pl && pl_we;
    pl_rvalid    = rst_n && rd_owner == O_PL;
    ld_rvalid    = rst_n && rd_owner == O_LD;
    pl_rdata     = pl_rvalid ? dmem_dout : '0;
    ld_rdata     = ld_rvalid ? dmem_dout : '0;
  end
  always_comb begin
    state_nx    = g_ld ? S_LD : g_pl ? S_PL : S_IDLE;
    burst_nx    = !g_ld ? '0 : state != S_LD ? BW'(1) :
                  burst_cnt == BW'(MAX_BURST) ? burst_cnt : burst_cnt + BW'(1);
    starve_nx   = !ld_req || g_ld ? '0 :
                  starve_cnt == SW'(STARVE_LIM) ? starve_cnt : starve_cnt + SW'(1);
    rd_owner_nx = g_ld && !ld_we ? O_LD : g_pl && !pl_we ? O_PL : O_NONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_owner   <= O_NONE;
      burst_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      rd_owner   <= rd_owner_nx;
      burst_cnt  <= burst_nx;
      starve_cnt <= starve_nx;
    end
  end
endmodule
